instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0: the first fetch address after reset.
REQ-002 Parameter QUEUE_DEPTH, default 4: the fetch-queue entry count, a power of two from 2 to 16.
REQ-003 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  the reset, synchronous and active-low.
REQ-005 redirect_valid  input  1  a taken branch or jump from the EX/MEM stage.
REQ-006 redirect_pc  input  64  the redirect target; bits [1:0] SHALL be treated as zero.
REQ-007 imem_req_valid  output  1  an instruction memory request is presented.
REQ-008 imem_req_addr  output  64  the request address.
REQ-009 imem_req_ready  input  1  the memory accepts the request this cycle.
REQ-010 imem_rsp_valid  input  1  a response is valid; responses SHALL arrive in order, at least 1 cycle after acceptance.
REQ-011 imem_rsp_instr  input  32  the response instruction word.
REQ-012 fetch_valid  output  1  the head instruction is available to IF_ID.
REQ-013 fetch_pc  output  64  the head instruction's PC.
REQ-014 fetch_instr  output  32  the head instruction.
REQ-015 fetch_ready  input  1  IF_ID accepts the head this cycle; it is driven from IF_ID_write.
REQ-016 queue_count  output  $clog2(QUEUE_DEPTH)+1  the number of occupied queue entries.

Function
REQ-017 Every queue entry SHALL hold {pc[63:0], instr[31:0]}; the queue SHALL be a circular buffer whose read and write pointers wrap modulo QUEUE_DEPTH.
REQ-018 The block SHALL allow at most one outstanding request at any time.
REQ-019 A request SHALL be issued only when queue_count plus outstanding is less than QUEUE_DEPTH, so a response never finds the queue full.
REQ-020 A request is accepted when imem_req_valid and imem_req_ready are both high; on acceptance, next_pc SHALL advance by 4 modulo 2^64, and the issued PC SHALL be tagged to the outstanding slot.
REQ-021 The FSM SHALL have three states:
- FETCH: no request is outstanding. Go to WAIT on acceptance.
- WAIT: a request is outstanding. On imem_rsp_valid, go to FETCH.
- DRAIN: a stale request is outstanding. On imem_rsp_valid, go to FETCH.
REQ-022 imem_req_valid SHALL be asserted only in FETCH, and only when the credit rule of REQ-019 holds and redirect_valid is low.
REQ-023 A response received in WAIT SHALL be written to the queue tail with its tagged PC.
REQ-024 A response received in DRAIN SHALL be discarded.
REQ-025 fetch_valid SHALL equal (queue_count != 0), and fetch_pc/fetch_instr SHALL show the head entry.
REQ-026 A pop occurs when fetch_valid and fetch_ready are both high.
REQ-027 A push and a pop in the same cycle SHALL leave queue_count unchanged.
REQ-028 When fetch_ready is low, the head SHALL hold stable and the queue SHALL keep filling up to the credit limit.
REQ-029 On redirect_valid, the block SHALL on the next edge:
- empty the queue;
- set next_pc to redirect_pc;
- enter DRAIN if a request is outstanding and no response arrives in that cycle, otherwise enter FETCH.
REQ-030 redirect_valid SHALL take priority over a simultaneous push or pop; a response arriving in the redirect cycle SHALL be discarded.
REQ-031 Back-to-back redirects SHALL each overwrite next_pc; the last one wins.
REQ-032 A redirect in DRAIN SHALL remain in DRAIN.
REQ-033 The latency from response to fetch_valid SHALL be 1 cycle; the minimum latency from redirect to a request for redirect_pc SHALL be 1 cycle.

Reset
REQ-034 While reset is low at a rising edge, the block SHALL set next_pc = RESET_PC, clear both queue pointers and queue_count, clear outstanding, and enter FETCH.
REQ-035 In the cycle after that edge, imem_req_valid = 0, fetch_valid = 0 and queue_count = 0.
REQ-036 imem_rsp_valid SHALL be ignored while reset is low.
REQ-037 The instruction memory SHALL be reset by the same reset signal, so no response survives a reset.
REQ-038 A reset asserted mid-operation SHALL override any redirect, push or pop in that cycle.

Configuration
REQ-039 With macro IFU_BYPASS_EN defined, a response received in WAIT while queue_count = 0 and fetch_ready = 1 SHALL be presented combinationally on fetch_valid, fetch_pc and fetch_instr in that same cycle, and SHALL NOT be written to the queue.
REQ-040 With IFU_BYPASS_EN undefined, every response SHALL pass through the queue (REQ-033 latency).
REQ-041 The bypass SHALL be suppressed during a redirect cycle.

Verification
REQ-042 Reset with RESET_PC = 64'h100 and single-cycle memory latency -> requests go out at 0x100, 0x104, 0x108; fetch_pc follows the same sequence; at most 1 request is outstanding.
REQ-043 Hold fetch_ready = 0 for 20 cycles -> queue_count saturates at 4, imem_req_valid stays low at count 4, and the head stays at 0x100.
REQ-044 Redirect to 0x2000 while a request is outstanding with 3-cycle memory latency -> the stale response is dropped, the queue empties, and the next request and next fetch_pc are 0x2000.
REQ-045 Redirect in the same cycle as imem_rsp_valid and fetch_ready -> nothing is pushed, queue_count = 0 next cycle, and state = FETCH.
REQ-046 next_pc = 64'hFFFF_FFFF_FFFF_FFFC -> the following request address is 64'h0.
REQ-047 With IFU_BYPASS_EN defined, empty queue, rsp_valid and fetch_ready -> fetch_valid = 1 in the same cycle and queue_count stays 0; with the macro undefined -> fetch_valid rises the next cycle.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: redirect, imem request/response and IF_ID fetch handshake bundle (master = fetch unit side)
interface instr_fetch_unit_if;
  logic redirect_valid;
  logic [63:0] redirect_pc;
  logic imem_req_valid;
  logic [63:0] imem_req_addr;
  logic imem_req_ready;
  logic imem_rsp_valid;
  logic [31:0] imem_rsp_instr;
  logic fetch_valid;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic fetch_ready;
  modport master (
    input redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_instr, fetch_ready,
    output imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_instr
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_instr, fetch_ready,
    input imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_instr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding imem fetcher feeding a circular {pc,instr} queue, with redirect drain and optional same-cycle bypass under IFU_BYPASS_EN
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int QUEUE_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  instr_fetch_unit_if.master bus,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);
  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;
  state_t state;
  logic [63:0] next_pc, tag_pc;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [63:0] pc_q [QUEUE_DEPTH];
  logic [31:0] ins_q [QUEUE_DEPTH];
  logic accept, push, pop, byp, head_valid;
  always_comb begin
    head_valid = queue_count != '0;
    bus.imem_req_valid = reset && state == FETCH && queue_count < DEPTH && !bus.redirect_valid;
    bus.imem_req_addr = next_pc;
    accept = bus.imem_req_valid && bus.imem_req_ready;
`ifdef IFU_BYPASS_EN
    byp = reset && state == WAIT && bus.imem_rsp_valid && !head_valid && bus.fetch_ready && !bus.redirect_valid;
`else
    byp = 1'b0;
`endif
    push = state == WAIT && bus.imem_rsp_valid && !bus.redirect_valid && !byp;
    pop = head_valid && bus.fetch_ready && !bus.redirect_valid;
    bus.fetch_valid = head_valid || byp;
    bus.fetch_pc = byp ? tag_pc : pc_q[rd_ptr];
    bus.fetch_instr = byp ? bus.imem_rsp_instr : ins_q[rd_ptr];
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= FETCH;
      next_pc <= RESET_PC;
      tag_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      queue_count <= '0;
    end else begin
      rd_ptr <= bus.redirect_valid ? '0 : rd_ptr + PW'(pop);
      wr_ptr <= bus.redirect_valid ? '0 : wr_ptr + PW'(push);
      queue_count <= bus.redirect_valid ? '0 : queue_count + CW'(push) - CW'(pop);
      next_pc <= bus.redirect_valid ? bus.redirect_pc & ~64'h3 : accept ? next_pc + 64'd4 : next_pc;
      tag_pc <= accept ? next_pc : tag_pc;
      state <= bus.redirect_valid ? (state != FETCH && !bus.imem_rsp_valid ? DRAIN : FETCH) :
               state == FETCH ? (accept ? WAIT : FETCH) :
               bus.imem_rsp_valid ? FETCH : state;
    end
  always_ff @(posedge clk)
    if (reset && push) begin
      pc_q[wr_ptr] <= tag_pc;
      ins_q[wr_ptr] <= bus.imem_rsp_instr;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table vectors plus a memory model and fetch scoreboard for instr_fetch_unit
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h100;
  typedef struct packed {logic [63:0] pc; logic [31:0] ins;} ent_t;
  typedef struct {logic fr; logic rv; int cnt; logic fv; logic [63:0] pc;} vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] queue_count;
  int checks = 0;
  int errors = 0;
  int lat = 1;
  int wait_cnt = 0;
  int rsp_push = 0;
  logic busy = 1'b0;
  logic stale = 1'b0;
  logic [63:0] mem_addr, mem_pc;
  logic [63:0] exp_next_req = RESET_PC;
  ent_t exp_fetch[$];
  ent_t mon_e, new_e;
  vec_t tv[$];

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(logic [63:0] pc);
    return pc[63:32] ^ pc[31:0] ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(logic fr, logic rv, int cnt, logic fv, logic [63:0] pc);
    vec_t v;
    v.fr = fr; v.rv = rv; v.cnt = cnt; v.fv = fv; v.pc = pc;
    tv.push_back(v);
  endtask

  task automatic wait_req(string name, logic [63:0] exp);
    for (int i = 0; i < 50; i++) begin
      #3;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk(name, bus.imem_req_addr, exp);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL %s timeout waiting for request, required addr=%h", name, exp);
  endtask

  task automatic wait_fv(string name, logic [63:0] exp);
    for (int i = 0; i < 50; i++) begin
      #3;
      if (bus.fetch_valid) begin
        chk(name, bus.fetch_pc, exp);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL %s timeout waiting for fetch_valid, required pc=%h", name, exp);
  endtask

  task automatic do_reset(int l, logic rdr);
    reset = 1'b0;
    lat = l;
    bus.redirect_valid = rdr;
    bus.redirect_pc = 64'h7000;
    bus.fetch_ready = rdr;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #3;
    chk("rst_queue_count", 64'(queue_count), 64'd0);
    chk("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.fetch_ready = 1'b0;
  endtask

  // memory model: accepts one request, answers after lat cycles, pushes expected fetches
  initial forever begin
    @(negedge clk);
    #1;
    bus.imem_rsp_valid = 1'b0;
    rsp_push = 0;
    if (!reset) begin
      busy = 1'b0;
      stale = 1'b0;
      exp_fetch.delete();
      exp_next_req = RESET_PC;
    end else begin
      if (busy) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_instr = ins_of(mem_addr);
          busy = 1'b0;
          if (!stale && !bus.redirect_valid) begin
            new_e.pc = mem_pc;
            new_e.ins = ins_of(mem_pc);
            exp_fetch.push_back(new_e);
            rsp_push = 1;
          end
          stale = 1'b0;
        end
      end
      if (bus.redirect_valid) begin
        exp_fetch.delete();
        exp_next_req = bus.redirect_pc & ~64'h3;
        stale = busy;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("one_outstanding", 64'(busy), 64'd0);
        chk("req_addr", bus.imem_req_addr, exp_next_req);
        busy = 1'b1;
        wait_cnt = lat;
        mem_addr = bus.imem_req_addr;
        mem_pc = exp_next_req;
        exp_next_req += 64'd4;
      end
    end
  end

  // fetch monitor: occupancy and popped entries against the scoreboard
  initial forever begin
    @(negedge clk);
    #3;
    if (reset && !bus.redirect_valid) begin
      chk("queue_count", 64'(queue_count), 64'(exp_fetch.size() - rsp_push));
      if (bus.fetch_valid && bus.fetch_ready) begin
        if (exp_fetch.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_extra actual pc=%h required no fetch", bus.fetch_pc);
        end else begin
          mon_e = exp_fetch.pop_front();
          chk("fetch_pc", bus.fetch_pc, mon_e.pc);
          chk("fetch_instr", 64'(bus.fetch_instr), 64'(mon_e.ins));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 64'h0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_instr = 32'h0;
    bus.fetch_ready = 1'b0;
    add(0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 'h100);
    add(0, 0, 1, 1, 'h100);
    add(0, 1, 2, 1, 'h100);
    add(0, 0, 2, 1, 'h100);
    add(0, 1, 3, 1, 'h100);
    add(0, 0, 3, 1, 'h100);
    for (int i = 8; i < 20; i++) add(0, 0, 4, 1, 'h100);
    add(1, 0, 4, 1, 'h100);
    add(1, 1, 3, 1, 'h104);
    add(1, 0, 2, 1, 'h108);
    add(1, 1, 2, 1, 'h10c);
    add(1, 0, 1, 1, 'h110);
    add(1, 1, 1, 1, 'h114);
    @(negedge clk);
    do_reset(1, 1'b0);
    for (int i = 0; i < tv.size(); i++) begin
      bus.fetch_ready = tv[i].fr;
      #3;
      chk($sformatf("tv%0d_req_valid", i), 64'(bus.imem_req_valid), 64'(tv[i].rv));
      chk($sformatf("tv%0d_queue_count", i), 64'(queue_count), 64'(tv[i].cnt));
      chk($sformatf("tv%0d_fetch_valid", i), 64'(bus.fetch_valid), 64'(tv[i].fv));
      if (tv[i].fv) chk($sformatf("tv%0d_fetch_pc", i), bus.fetch_pc, tv[i].pc);
      @(negedge clk);
    end
    do_reset(3, 1'b0);
    bus.fetch_ready = 1'b1;
    wait_req("a_first_req", RESET_PC);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h4000;
    @(negedge clk);
    bus.redirect_pc = 64'h2003;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #3;
    chk("a_drain_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("a_drain_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    chk("a_drain_queue_count", 64'(queue_count), 64'd0);
    @(negedge clk);
    wait_req("a_redirect_req", 64'h2000);
    wait_fv("a_redirect_fetch", 64'h2000);
    do_reset(1, 1'b0);
    bus.fetch_ready = 1'b1;
    wait_req("b_first_req", RESET_PC);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h3000;
    #3;
    chk("b_rdr_rsp_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #3;
    chk("b_queue_count", 64'(queue_count), 64'd0);
    chk("b_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    chk("b_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("b_req_addr", bus.imem_req_addr, 64'h3000);
    @(negedge clk);
    do_reset(1, 1'b0);
    bus.fetch_ready = 1'b1;
    wait_req("d_first_req", RESET_PC);
    #3;
`ifdef IFU_BYPASS_EN
    chk("d_byp_fetch_valid", 64'(bus.fetch_valid), 64'd1);
    chk("d_byp_fetch_pc", bus.fetch_pc, RESET_PC);
    chk("d_byp_fetch_instr", 64'(bus.fetch_instr), 64'(ins_of(RESET_PC)));
    chk("d_byp_queue_count", 64'(queue_count), 64'd0);
    @(negedge clk);
    #3;
    chk("d_byp_next_queue_count", 64'(queue_count), 64'd0);
    chk("d_byp_next_fetch_valid", 64'(bus.fetch_valid), 64'd0);
`else
    chk("d_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    @(negedge clk);
    #3;
    chk("d_next_fetch_valid", 64'(bus.fetch_valid), 64'd1);
    chk("d_next_fetch_pc", bus.fetch_pc, RESET_PC);
    chk("d_next_queue_count", 64'(queue_count), 64'd1);
`endif
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'hffff_ffff_ffff_fffe;
    bus.imem_req_ready = 1'b0;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("c_stall_req_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("c_stall_req_addr", bus.imem_req_addr, 64'hffff_ffff_ffff_fffc);
      @(negedge clk);
    end
    bus.imem_req_ready = 1'b1;
    wait_req("c_top_req", 64'hffff_ffff_ffff_fffc);
    wait_req("c_wrap_req", 64'h0);
    for (int i = 0; i < 300; i++) begin
      bus.fetch_ready = $urandom_range(0, 3) != 0;
      bus.redirect_valid = $urandom_range(0, 19) == 0;
      bus.redirect_pc = {$urandom, $urandom};
      lat = $urandom_range(1, 3);
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;
    do_reset(1, 1'b1);
    bus.fetch_ready = 1'b1;
    wait_req("e_after_reset_req", RESET_PC);
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
